i2c_master_burst_ctrl: RTL

I2C_MASTER_BURST_CTRL -- requirements
Module: i2c_master_burst_ctrl

---
 rtl/i2c_master_burst_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_burst_ctrl.sv
// I2C burst master: turns byte-level burst requests into START/WRITE/READ/STOP bit commands, one command per core_ack.
// TX/RX byte FIFOs decouple data; TXLD/RXWAIT hold core_cmd at NOP on an empty TX or full RX FIFO.

// Generic synchronous FIFO, first-word fall-through; flush empties it and drops a coincident push.
module i2c_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module i2c_master_burst_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_read,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             done,
  output logic             nack,
  output logic             al,
  output logic [3:0]       core_cmd,
  output logic             core_txd,
  input  logic             core_ack,
  input  logic             core_rxd,
  input  logic             i2c_al
);
  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TXLD, S_WBIT, S_WACK, S_RXWAIT, S_RBIT, S_RACK, S_STOP
  } state_t;

  typedef struct packed {
    logic stop;
    logic read;
  } req_t;

  state_t           state;
  req_t             req;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_dec;
  logic [2:0]       bit_cnt;
  logic [7:0]       sr;
  logic             ready_en;

  logic             tx_full;
  logic             tx_empty;
  logic [7:0]       tx_head;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_flush;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;

  state_t           end_state;
  logic [3:0]       end_cmd;
  logic             end_done;
  state_t           data_state;

  assign cmd_ready = ready_en && (state == S_IDLE);
  assign tx_ready  = ready_en && !tx_full;
  assign rx_valid  = !rx_empty;
  assign rem_dec   = remaining - 1'b1;

  // End of a phase either closes the bus with STOP or leaves it held for a repeated START.
  assign end_state  = req.stop ? S_STOP : S_IDLE;
  assign end_cmd    = req.stop ? CMD_STOP : CMD_NOP;
  assign end_done   = !req.stop;
  assign data_state = req.read ? S_RXWAIT : S_TXLD;

  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = (state == S_TXLD) && !tx_empty;
  assign tx_flush = ((state != S_IDLE) && i2c_al) ||
                    ((state == S_WACK) && core_ack && core_rxd);
  assign rx_push  = (state == S_RACK) && core_ack && !i2c_al;
  assign rx_pop   = rx_ready && !rx_empty;

  i2c_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (tx_flush),
    .push     (tx_push),
    .push_dat (tx_data),
    .pop      (tx_pop),
    .pop_dat  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  i2c_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (rx_push),
    .push_dat (sr),
    .pop      (rx_pop),
    .pop_dat  (rx_data),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req       <= '0;
      remaining <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      ready_en  <= 1'b0;
      core_cmd  <= CMD_NOP;
      core_txd  <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      al        <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      // Arbitration loss outranks any coincident core_ack.
      if ((state != S_IDLE) && i2c_al) begin
        state    <= S_IDLE;
        core_cmd <= CMD_NOP;
        core_txd <= 1'b0;
        al       <= 1'b1;
        done     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              req       <= '{stop: cmd_stop, read: cmd_read};
              remaining <= cmd_len;
              nack      <= 1'b0;
              al        <= 1'b0;
              if (cmd_start) begin
                state    <= S_START;
                core_cmd <= CMD_START;
              end else if (cmd_len != '0) begin
                state <= cmd_read ? S_RXWAIT : S_TXLD;
              end else if (cmd_stop) begin
                state    <= S_STOP;
                core_cmd <= CMD_STOP;
              end else begin
                done <= 1'b1;
              end
            end
          end
          S_START: begin
            if (core_ack) begin
              if (remaining != '0) begin
                state    <= data_state;
                core_cmd <= CMD_NOP;
              end else begin
                state    <= end_state;
                core_cmd <= end_cmd;
                done     <= end_done;
              end
            end
          end
          S_TXLD: begin
            if (!tx_empty) begin
              sr       <= tx_head;
              core_txd <= tx_head[7];
              bit_cnt  <= '0;
              state    <= S_WBIT;
              core_cmd <= CMD_WRITE;
            end
          end
          S_WBIT: begin
            if (core_ack) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state    <= S_WACK;
                core_cmd <= CMD_READ;
                core_txd <= 1'b0;
              end else begin
                sr       <= {sr[6:0], 1'b0};
                core_txd <= sr[6];
              end
            end
          end
          S_WACK: begin
            if (core_ack) begin
              if (core_rxd) begin
                nack     <= 1'b1;
                state    <= end_state;
                core_cmd <= end_cmd;
                done     <= end_done;
              end else begin
                remaining <= rem_dec;
                if (rem_dec != '0) begin
                  state    <= S_TXLD;
                  core_cmd <= CMD_NOP;
                end else begin
                  state    <= end_state;
                  core_cmd <= end_cmd;
                  done     <= end_done;
                end
              end
            end
          end
          S_RXWAIT: begin
            if (!rx_full) begin
              bit_cnt  <= '0;
              state    <= S_RBIT;
              core_cmd <= CMD_READ;
            end
          end
          S_RBIT: begin
            if (core_ack) begin
              sr      <= {sr[6:0], core_rxd};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state    <= S_RACK;
                core_cmd <= CMD_WRITE;
                core_txd <= (remaining > LEN_W'(1)) ? 1'b0 : 1'b1;
              end
            end
          end
          S_RACK: begin
            if (core_ack) begin
              core_txd  <= 1'b0;
              remaining <= rem_dec;
              if (rem_dec != '0) begin
                state    <= S_RXWAIT;
                core_cmd <= CMD_NOP;
              end else begin
                state    <= end_state;
                core_cmd <= end_cmd;
                done     <= end_done;
              end
            end
          end
          S_STOP: begin
            if (core_ack) begin
              state    <= S_IDLE;
              core_cmd <= CMD_NOP;
              done     <= 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            core_cmd <= CMD_NOP;
          end
        endcase
      end
    end
  end
endmodule
